ucb_nib_rcv: RTL
================

# ucb_nib_rcv

Receive end of the IOB 4-bit UCB downstream link, on the jbus clock, in a peripheral block (DRAM, SPI or TAP agent). It samples `vld`/`data` nibbles driven by the IOB and assembles them into a 64-bit header-only request or a 128-bit write request. It hands each complete request to local logic over a valid/ack handshake and back-pressures the IOB through `stall`.

## Interface
- `WR_TYPE`, default 4'b0101: header packet-type code, header bits [3:0], that marks a write request carrying a 64-bit data beat. Every other type is header-only.
- `jbus_gclk`  in  1  jbus clock; all flops on the rising edge.
- `jbus_arst_l`  in  1  asynchronous, active-low reset.
- `iob_ucb_vld`  in  1  nibble valid from the IOB.
- `iob_ucb_data`  in  4  nibble; least-significant nibble first.
- `ucb_iob_stall`  out  1  registered back-pressure to the IOB.
- `req_vld`  out  1  complete request held in the output register.
- `req_hdr`  out  64  request header.
- `req_data`  out  64  write data; 0 for header-only packets.
- `req_wr`  out  1  1 when the header type equals `WR_TYPE`.
- `req_ack`  in  1  consumer accepts the request; meaningful only while `req_vld`=1.
- `proto_err`  out  1  sticky protocol-violation flag, cleared only by reset.

## Operation
- Assembly register: 128 bits, plus a 5-bit nibble count (0..31) and a `pend` flag.
- Nibble capture: each cycle with `iob_ucb_vld`=1 and `pend`=0 writes the nibble to bits [4*cnt+3:4*cnt] and increments `cnt`. Gaps (`vld`=0) pause assembly without losing state.
- Packet end:
  - On the 16th nibble (`cnt`=15), if bits [3:0] != `WR_TYPE`, the packet is complete.
  - Otherwise the packet completes on the 32nd nibble (`cnt`=31).
  - `cnt` returns to 0 on completion.
- Output register: holds `req_hdr`, `req_data`, `req_wr` and `req_vld`.
  - A completed packet moves into it on the completing edge if it is empty, or is being acked on that edge.
  - Otherwise the packet stays in the assembly register and `pend` is set.
- Pending transfer: while `pend`=1, a `req_ack` moves the pending packet into the output register on the same edge, so `req_vld` stays 1 with the new contents, and `pend` clears.
- Stall rule: `ucb_iob_stall` next-state = output register full after this edge. The IOB must not start a new packet while it samples stall=1, but may finish the packet in progress.
- Protocol violation: `iob_ucb_vld`=1 while `pend`=1 sets `proto_err` and drops the nibble; assembly state is unchanged.
- `req_data` is 0 whenever `req_wr`=0.

## Timing
- Reset (asynchronous, any cycle, including mid-packet):
  - `req_vld`, `req_wr`, `ucb_iob_stall`, `proto_err` = 0; `req_hdr`, `req_data` = 0.
  - `cnt`=0, `pend`=0; any partial packet is discarded.
- Latency: final nibble sampled at edge N gives `req_vld`=1 from edge N onward (visible in cycle N+1) when the output register is free.
- Stall timing: `ucb_iob_stall` rises the same edge `req_vld` rises. It falls on the edge where `req_ack` empties the register with `pend`=0.
- Back-to-back: an ack in the same cycle as the completing nibble gives a seamless hand-over, with no gap in `req_vld`.
- Ack while `req_vld`=0 is ignored.
- Nibbles arriving while the output is full but `pend`=0 continue to assemble normally.

## Test plan
- Read request: 16 nibbles forming header 0x0123_4567_89AB_CD04, back-to-back `vld`.
  - → `req_vld`=1 one cycle after the last nibble; `req_hdr` matches, `req_wr`=0, `req_data`=0, stall=1.
  - `req_ack` → `req_vld`=0 and stall=0 the next cycle.
- Write request: header with type 0x5 and data 0xDEAD_BEEF_CAFE_F00D over 32 nibbles, with 3-cycle `vld` gaps after nibbles 7 and 20.
  - → `req_wr`=1 and `req_data` matches exactly once; `req_vld` does not rise early after nibble 16.
- Back-pressure: two read packets sent back-to-back, no ack.
  - → first packet held; second packet pends (`pend`=1).
  - Ack → second packet appears the next cycle with no `req_vld` gap; a second ack → stall=0.
- Simultaneous events: ack in the same cycle as a packet's final nibble with the output full.
  - → new packet replaces the old with no gap; `pend` stays 0.
- Protocol error: while `pend`=1, drive 2 extra nibbles.
  - → `proto_err`=1 and sticky; pending and held packets are unchanged on later acks.
- Reset mid-operation: assert `jbus_arst_l`=0 after nibble 9 of a write, between clock edges.
  - → all outputs 0 immediately.
  - Release reset, send a fresh read request → decoded correctly from nibble 0.

Source files
------------

// File: rtl/ucb_nib_rcv.sv
// ucb_nib_rcv: receive end of the 4-bit UCB downstream link.
// Nibbles arrive least-significant first and are assembled into a 64-bit
// header-only request or a 128-bit write request (header + data beat).
// A completed request goes to a single output register handed to local
// logic over valid/ack. If that register is occupied and not being acked,
// the request waits in the assembly register ("pend"). The IOB is
// back-pressured through a registered stall that mirrors output occupancy.
module ucb_nib_rcv #(
    parameter logic [3:0] WR_TYPE = 4'b0101
) (
    input  logic        jbus_gclk,
    input  logic        jbus_arst_l,
    input  logic        iob_ucb_vld,
    input  logic [3:0]  iob_ucb_data,
    output logic        ucb_iob_stall,
    output logic        req_vld,
    output logic [63:0] req_hdr,
    output logic [63:0] req_data,
    output logic        req_wr,
    input  logic        req_ack,
    output logic        proto_err
);

    localparam int NIB_TOTAL = 32;

    // Assembly state
    logic [127:0] asm_q, asm_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         pend_q, pend_d;

    // Output register
    logic         vld_q, vld_d;
    logic [63:0]  hdr_q, hdr_d;
    logic [63:0]  data_q, data_d;
    logic         wr_q, wr_d;
    logic         stall_q, stall_d;
    logic         err_q, err_d;

    // Per-cycle decode
    logic         capture;
    logic         hdr_done;
    logic         full_done;
    logic         done;
    logic         ack_eff;
    logic         out_free;
    logic         load_out;
    logic         fill_wr;
    logic [127:0] asm_fill;

    // A nibble is accepted only when no completed packet is parked in the
    // assembly register; otherwise it would corrupt the pending packet.
    assign capture = iob_ucb_vld & ~pend_q;

    // Ack has no effect unless the output register actually holds a request.
    assign ack_eff = req_ack & vld_q;

    // The output register can take a new request this edge if it is empty
    // or its current contents are being consumed on this same edge.
    assign out_free = ~vld_q | ack_eff;

    // Assembly register with the current nibble merged into its slot. When
    // pend is set no nibble is merged, so this is simply the parked packet.
    for (genvar gi = 0; gi < NIB_TOTAL; gi++) begin : g_nib
        assign asm_fill[4*gi +: 4] = (capture && (cnt_q == 5'(gi)))
                                     ? iob_ucb_data
                                     : asm_q[4*gi +: 4];
    end

    // The packet type sits in nibble 0, which is already registered by the
    // time the 16th nibble arrives, so asm_q[3:0] is valid for the decision.
    assign hdr_done  = capture && (cnt_q == 5'd15) && (asm_q[3:0] != WR_TYPE);
    assign full_done = capture && (cnt_q == 5'd31);
    assign done      = hdr_done | full_done;

    // Type of whatever is in asm_fill: a fresh completion or the parked one.
    assign fill_wr = (asm_fill[3:0] == WR_TYPE);

    // Output load: either the parked packet moves on ack, or a packet that
    // completes this edge goes straight through when the register is free.
    assign load_out = (pend_q & ack_eff) | (done & out_free);

    // Next-state logic for assembly and output registers
    always_comb begin
        asm_d   = asm_fill;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        vld_d   = vld_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        err_d   = err_q;

        if (done) begin
            cnt_d = 5'd0;
        end else if (capture) begin
            cnt_d = cnt_q + 5'd1;
        end

        if (pend_q && ack_eff) begin
            pend_d = 1'b0;
        end else if (done && !out_free) begin
            pend_d = 1'b1;
        end

        if (load_out) begin
            vld_d  = 1'b1;
            hdr_d  = asm_fill[63:0];
            wr_d   = fill_wr;
            data_d = fill_wr ? asm_fill[127:64] : 64'd0;
        end else if (ack_eff) begin
            vld_d  = 1'b0;
        end

        // Violation: IOB drove a nibble while a packet was parked.
        if (iob_ucb_vld && pend_q) begin
            err_d = 1'b1;
        end

        stall_d = vld_d;
    end

    // Assembly state registers
    always_ff @(posedge jbus_gclk or negedge jbus_arst_l) begin
        if (!jbus_arst_l) begin
            asm_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    // Output, stall and error registers
    always_ff @(posedge jbus_gclk or negedge jbus_arst_l) begin
        if (!jbus_arst_l) begin
            vld_q   <= 1'b0;
            hdr_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign req_vld       = vld_q;
    assign req_hdr       = hdr_q;
    assign req_data      = data_q;
    assign req_wr        = wr_q;
    assign ucb_iob_stall = stall_q;
    assign proto_err     = err_q;

endmodule
